// File: rtl/dc_update_sequencer.sv
// dc_update_sequencer
// Takes decoded DC-bias channel frames and launch commands from the command
// dispatcher and feeds them to the DAC SPI write engine. A frame is copied
// into a shadow buffer and streamed word by word over a valid/ready link.
// A launch command that was queued behind the frame is released only after
// a settle interval. A launch with nothing ahead of it is released at once.
// Frames that arrive while the block is busy, and launch commands that
// overwrite a still-pending launch, are discarded and counted.

module dc_update_sequencer #(
  parameter int DAC_CHANNEL   = 24,
  parameter int N_WORDS       = 61,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_frame_valid,
  input  logic [4:0]             i_channel_sel,
  input  logic [N_WORDS*32-1:0]  i_dc_regs,
  input  logic                   i_launch_valid,
  input  logic [127:0]           i_launch_cmd,
  output logic                   o_wr_valid,
  input  logic                   i_wr_ready,
  output logic [4:0]             o_wr_channel,
  output logic [5:0]             o_wr_addr,
  output logic [31:0]            o_wr_data,
  output logic                   o_frame_done,
  output logic                   o_launch_start,
  output logic [127:0]           o_launch_cmd,
  output logic                   o_busy,
  output logic                   o_drop,
  output logic [15:0]            o_drop_cnt
);

  localparam int              CNT_W       = $clog2(SETTLE_CYCLES + 1);
  localparam logic [5:0]      LAST_IDX    = 6'(N_WORDS - 1);
  localparam logic [5:0]      CH_LIMIT    = 6'(DAC_CHANNEL);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_SETTLE,
    ST_LAUNCH
  } state_t;

  state_t             state_q;
  logic [31:0]        frameBuf_q [N_WORDS];
  logic [4:0]         chan_q;
  logic [5:0]         idx_q;
  logic [CNT_W-1:0]   settleCnt_q;
  logic               pendValid_q;
  logic [127:0]       pendCmd_q;
  logic [127:0]       launchCmd_q;
  logic               launchStart_q;
  logic               frameDone_q;
  logic               drop_q;
  logic [15:0]        dropCnt_q;
  logic [15:0]        dropCnt_d;

  logic               chanLegal;
  logic               frameAccept;
  logic               wordAccept;
  logic               frameDrop;
  logic               launchDrop;
  logic [127:0]       launchSrc;
  logic [16:0]        dropSum;

  // Decode this cycle's strobes against the current state: what is accepted,
  // what is discarded, and which command a launch would release right now.
  always_comb begin
    chanLegal   = ({1'b0, i_channel_sel} < CH_LIMIT);
    frameAccept = (state_q == ST_IDLE) && i_frame_valid && chanLegal;
    wordAccept  = (state_q == ST_STREAM) && i_wr_ready;
    // Any frame that cannot start a stream immediately is lost; a launch is
    // lost only when it overwrites a command still waiting in the slot.
    frameDrop   = i_frame_valid && ((state_q != ST_IDLE) || !chanLegal);
    launchDrop  = i_launch_valid && pendValid_q;
    // A launch strobe arriving in the very cycle a launch is released is the
    // newest command, so it wins over whatever sat in the pending slot.
    launchSrc   = i_launch_valid ? i_launch_cmd : pendCmd_q;
    dropSum     = {1'b0, dropCnt_q} + {16'd0, frameDrop} + {16'd0, launchDrop};
    dropCnt_d   = dropSum[16] ? 16'hFFFF : dropSum[15:0];
  end

  // Shadow buffer: written only when a frame is accepted from IDLE, so its
  // contents never change while a stream is in progress. It needs no reset
  // because the write data output is gated by o_wr_valid.
  always_ff @(posedge i_clk) begin
    if (frameAccept) begin
      for (int w = 0; w < N_WORDS; w++) begin
        frameBuf_q[w] <= i_dc_regs[w*32 +: 32];
      end
    end
  end

  // Sequencer state machine with its registered status, launch and drop outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= ST_IDLE;
      chan_q        <= '0;
      idx_q         <= '0;
      settleCnt_q   <= '0;
      pendValid_q   <= 1'b0;
      pendCmd_q     <= '0;
      launchCmd_q   <= '0;
      launchStart_q <= 1'b0;
      frameDone_q   <= 1'b0;
      drop_q        <= 1'b0;
      dropCnt_q     <= '0;
    end else begin
      frameDone_q   <= 1'b0;
      launchStart_q <= 1'b0;
      drop_q        <= frameDrop | launchDrop;
      dropCnt_q     <= dropCnt_d;

      // Every launch strobe lands in the pending slot, replacing any older
      // command; the release branches below empty the slot again.
      if (i_launch_valid) begin
        pendValid_q <= 1'b1;
        pendCmd_q   <= i_launch_cmd;
      end

      case (state_q)
        ST_IDLE: begin
          if (frameAccept) begin
            chan_q  <= i_channel_sel;
            idx_q   <= '0;
            state_q <= ST_STREAM;
          end else if (i_launch_valid || pendValid_q) begin
            launchCmd_q   <= launchSrc;
            launchStart_q <= 1'b1;
            pendValid_q   <= 1'b0;
            state_q       <= ST_LAUNCH;
          end
        end

        ST_STREAM: begin
          if (wordAccept) begin
            idx_q <= idx_q + 6'd1;
            if (idx_q == LAST_IDX) begin
              frameDone_q <= 1'b1;
              if (pendValid_q || i_launch_valid) begin
                settleCnt_q <= SETTLE_LOAD;
                state_q     <= ST_SETTLE;
              end else begin
                state_q <= ST_IDLE;
              end
            end
          end
        end

        ST_SETTLE: begin
          if (settleCnt_q == SETTLE_LAST) begin
            settleCnt_q   <= '0;
            launchCmd_q   <= launchSrc;
            launchStart_q <= 1'b1;
            pendValid_q   <= 1'b0;
            state_q       <= ST_LAUNCH;
          end else begin
            settleCnt_q <= settleCnt_q - SETTLE_LAST;
          end
        end

        ST_LAUNCH: begin
          state_q <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_wr_valid     = (state_q == ST_STREAM);
  assign o_wr_channel   = o_wr_valid ? chan_q : 5'd0;
  assign o_wr_addr      = o_wr_valid ? idx_q : 6'd0;
  assign o_wr_data      = o_wr_valid ? frameBuf_q[idx_q] : 32'd0;
  assign o_frame_done   = frameDone_q;
  assign o_launch_start = launchStart_q;
  assign o_launch_cmd   = launchCmd_q;
  assign o_busy         = (state_q != ST_IDLE);
  assign o_drop         = drop_q;
  assign o_drop_cnt     = dropCnt_q;

endmodule

// File: tb/tb_dc_update_sequencer.sv
// Testbench for dc_update_sequencer.
// The stimulus process issues frames and launch commands and pushes the
// expected writes, launches and drops into queues. A monitor running on the
// falling clock edge pops and compares whenever the DUT shows a word, a
// launch strobe or a drop pulse.

module tb_dc_update_sequencer;

  localparam int NW     = 61;
  localparam int NCH    = 24;
  localparam int SETTLE = 16;

  logic              clk;
  logic              rstN;
  logic              frameValid;
  logic [4:0]        chanSel;
  logic [NW*32-1:0]  dcRegs;
  logic              launchValid;
  logic [127:0]      launchCmd;
  logic              wrValid;
  logic              wrReady;
  logic [4:0]        wrChannel;
  logic [5:0]        wrAddr;
  logic [31:0]       wrData;
  logic              frameDone;
  logic              launchStart;
  logic [127:0]      launchCmdOut;
  logic              busy;
  logic              drop;
  logic [15:0]       dropCnt;

  typedef struct {
    logic [4:0]  ch;
    logic [5:0]  addr;
    logic [31:0] data;
  } wordExp_t;

  typedef struct {
    logic [127:0] cmd;
    bit           afterStream;
    int           cyc;
  } launchExp_t;

  typedef struct {
    int cyc;
    int weight;
  } dropExp_t;

  wordExp_t   wrQ[$];
  launchExp_t launchQ[$];
  dropExp_t   dropQ[$];

  int           total       = 0;
  int           bad         = 0;
  int           cyc         = 0;
  int           lastAccCyc  = -100;
  int           expDoneCyc  = -100;
  int           expDropCnt  = 0;
  logic [127:0] lastLaunchCmd = '0;
  int           readyMode   = 0;
  int           rdyCnt      = 0;
  bit           stallPrev   = 0;
  wordExp_t     monW;
  launchExp_t   monL;
  dropExp_t     monD;

  dc_update_sequencer #(
    .DAC_CHANNEL  (NCH),
    .N_WORDS      (NW),
    .SETTLE_CYCLES(SETTLE)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rstN),
    .i_frame_valid (frameValid),
    .i_channel_sel (chanSel),
    .i_dc_regs     (dcRegs),
    .i_launch_valid(launchValid),
    .i_launch_cmd  (launchCmd),
    .o_wr_valid    (wrValid),
    .i_wr_ready    (wrReady),
    .o_wr_channel  (wrChannel),
    .o_wr_addr     (wrAddr),
    .o_wr_data     (wrData),
    .o_frame_done  (frameDone),
    .o_launch_start(launchStart),
    .o_launch_cmd  (launchCmdOut),
    .o_busy        (busy),
    .o_drop        (drop),
    .o_drop_cnt    (dropCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of strobes; strobeCyc is the monitor cycle in which the
  // strobe is sampled, so registered responses appear at strobeCyc+1.
  task automatic applyStimulus(input bit fv, input logic [4:0] ch,
                               input logic [NW*32-1:0] regs, input bit lv,
                               input logic [127:0] cmd, output int strobeCyc);
    frameValid  = fv;
    chanSel     = ch;
    dcRegs      = regs;
    launchValid = lv;
    launchCmd   = cmd;
    strobeCyc   = cyc + 1;
    tick();
    frameValid  = 1'b0;
    launchValid = 1'b0;
  endtask

  function automatic logic [NW*32-1:0] makePayload(input bit incr, input logic [31:0] base);
    logic [NW*32-1:0] p;
    for (int i = 0; i < NW; i++) begin
      p[i*32 +: 32] = incr ? base + 32'(i) : $urandom();
    end
    return p;
  endfunction

  function automatic logic [127:0] randCmd();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic expectFrame(input logic [4:0] ch, input logic [NW*32-1:0] regs);
    for (int i = 0; i < NW; i++) begin
      wrQ.push_back('{ch, 6'(i), regs[i*32 +: 32]});
    end
  endtask

  task automatic expectDrop(input int c, input int w);
    dropQ.push_back('{c, w});
  endtask

  task automatic expectLaunch(input logic [127:0] cmd, input bit after, input int c);
    launchQ.push_back('{cmd, after, c});
  endtask

  task automatic clearModel();
    wrQ.delete();
    launchQ.delete();
    dropQ.delete();
    expDropCnt    = 0;
    expDoneCyc    = -100;
    lastAccCyc    = -100;
    lastLaunchCmd = '0;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_wr_valid"}, wrValid, 0);
    checkOutput({tag, "_wr_channel"}, wrChannel, 0);
    checkOutput({tag, "_wr_addr"}, wrAddr, 0);
    checkOutput({tag, "_wr_data"}, wrData, 0);
    checkOutput({tag, "_frame_done"}, frameDone, 0);
    checkOutput({tag, "_launch_start"}, launchStart, 0);
    checkOutput({tag, "_launch_cmd"}, launchCmdOut, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_drop"}, drop, 0);
    checkOutput({tag, "_drop_cnt"}, dropCnt, 0);
  endtask

  // Wait until every expected event has been seen, then confirm the block
  // has gone idle and the last launch command is still held.
  task automatic waitQuiet(input string tag);
    int n = 0;
    while ((wrQ.size() != 0 || launchQ.size() != 0 || dropQ.size() != 0 ||
            expDoneCyc >= cyc) && n < 4000) begin
      tick();
      n++;
    end
    if (n >= 4000) begin
      checkOutput({tag, "_timeout"}, 1, 0);
      wrQ.delete();
      launchQ.delete();
      dropQ.delete();
    end
    repeat (3) tick();
    checkOutput({tag, "_idle_busy"}, busy, 0);
    checkOutput({tag, "_idle_valid"}, wrValid, 0);
    checkOutput({tag, "_launch_hold"}, launchCmdOut, lastLaunchCmd);
    checkOutput({tag, "_drop_cnt"}, dropCnt, 16'(expDropCnt));
  endtask

  // Write-engine ready pattern: always high, high one cycle in three, or random.
  initial begin
    wrReady = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (readyMode)
        0:       wrReady = 1'b1;
        1:       wrReady = (rdyCnt % 3 == 2);
        default: wrReady = 1'($urandom_range(0, 1));
      endcase
      rdyCnt++;
    end
  end

  // Monitor: compares every presented word, frame-done pulse, launch strobe
  // and drop pulse against the front of the expectation queues.
  always @(negedge clk) begin
    cyc++;
    if (!rstN) begin
      stallPrev = 1'b0;
    end else begin
      if (stallPrev) checkOutput("valid_held", wrValid, 1);
      stallPrev = wrValid && !wrReady;

      if (wrValid) begin
        if (wrQ.size() == 0) begin
          checkOutput("unexpected_word", 1, 0);
        end else begin
          monW = wrQ[0];
          checkOutput("word", {wrChannel, wrAddr, wrData}, {monW.ch, monW.addr, monW.data});
          if (wrReady) begin
            void'(wrQ.pop_front());
            if (monW.addr == 6'(NW - 1)) begin
              lastAccCyc = cyc;
              expDoneCyc = cyc + 1;
            end
          end
        end
      end

      if (frameDone || cyc == expDoneCyc) begin
        checkOutput("frame_done", frameDone, cyc == expDoneCyc);
      end

      if (launchStart) begin
        if (launchQ.size() == 0) begin
          checkOutput("unexpected_launch", 1, 0);
        end else begin
          monL = launchQ.pop_front();
          checkOutput("launch_cmd", launchCmdOut, monL.cmd);
          checkOutput("launch_cycle", cyc,
                      monL.afterStream ? lastAccCyc + SETTLE + 1 : monL.cyc);
          lastLaunchCmd = monL.cmd;
        end
      end

      if (drop) begin
        if (dropQ.size() == 0) begin
          checkOutput("unexpected_drop", 1, 0);
        end else begin
          monD = dropQ.pop_front();
          checkOutput("drop_cycle", cyc, monD.cyc);
          expDropCnt = expDropCnt + monD.weight;
          if (expDropCnt > 65535) expDropCnt = 65535;
          checkOutput("drop_cnt", dropCnt, 16'(expDropCnt));
        end
      end
    end
  end

  initial begin
    int s;
    logic [NW*32-1:0] p;
    logic [127:0] c1;
    logic [127:0] c2;
    logic [4:0] ch;

    rstN        = 1'b0;
    frameValid  = 1'b0;
    launchValid = 1'b0;
    chanSel     = '0;
    dcRegs      = '0;
    launchCmd   = '0;
    repeat (3) tick();
    checkResetOutputs("por");
    rstN = 1'b1;
    tick();

    $display("[TB] frame ch5, ready high");
    readyMode = 0;
    p = makePayload(1, 32'h1000);
    applyStimulus(1, 5'd5, p, 0, '0, s);
    expectFrame(5'd5, p);
    waitQuiet("frame_ready_high");

    $display("[TB] frame ch5, ready one in three");
    readyMode = 1;
    applyStimulus(1, 5'd5, p, 0, '0, s);
    expectFrame(5'd5, p);
    waitQuiet("frame_ready_stall");

    $display("[TB] frame and launch together");
    readyMode = 0;
    c1 = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    applyStimulus(1, 5'd5, p, 1, c1, s);
    expectFrame(5'd5, p);
    expectLaunch(c1, 1, 0);
    waitQuiet("frame_then_launch");

    $display("[TB] drops while streaming");
    p = makePayload(0, 0);
    applyStimulus(1, 5'd9, p, 0, '0, s);
    expectFrame(5'd9, p);
    repeat (8) tick();
    applyStimulus(1, 5'd3, makePayload(0, 0), 0, '0, s);
    expectDrop(s + 1, 1);
    repeat (4) tick();
    c1 = randCmd();
    applyStimulus(0, 5'd0, p, 1, c1, s);
    repeat (4) tick();
    c2 = randCmd();
    applyStimulus(0, 5'd0, p, 1, c2, s);
    expectDrop(s + 1, 1);
    expectLaunch(c2, 1, 0);
    waitQuiet("stream_drops");
    checkOutput("drop_cnt_two", dropCnt, 2);

    rstN = 1'b0;
    clearModel();
    repeat (2) tick();
    rstN = 1'b1;
    tick();

    $display("[TB] illegal channel and launch alone");
    applyStimulus(1, 5'd24, p, 0, '0, s);
    expectDrop(s + 1, 1);
    waitQuiet("bad_channel");
    checkOutput("drop_cnt_one", dropCnt, 1);
    c1 = randCmd();
    applyStimulus(0, 5'd0, p, 1, c1, s);
    expectLaunch(c1, 0, s + 1);
    waitQuiet("launch_alone");

    $display("[TB] back-to-back launches");
    c1 = randCmd();
    c2 = randCmd();
    applyStimulus(0, 5'd0, p, 1, c1, s);
    expectLaunch(c1, 0, s + 1);
    applyStimulus(0, 5'd0, p, 1, c2, s);
    expectLaunch(c2, 0, s + 2);
    waitQuiet("launch_pair");

    $display("[TB] reset at word 30");
    readyMode = 0;
    p = makePayload(0, 0);
    applyStimulus(1, 5'd7, p, 0, '0, s);
    expectFrame(5'd7, p);
    repeat (30) tick();
    rstN = 1'b0;
    #1;
    checkResetOutputs("mid_reset");
    clearModel();
    tick();
    tick();
    rstN = 1'b1;
    tick();
    p = makePayload(1, 32'h2000);
    applyStimulus(1, 5'd2, p, 0, '0, s);
    expectFrame(5'd2, p);
    waitQuiet("after_reset");

    $display("[TB] randomized scenarios");
    for (int it = 0; it < 14; it++) begin
      readyMode = $urandom_range(0, 2);
      p = makePayload(0, 0);
      c1 = randCmd();
      c2 = randCmd();
      case ($urandom_range(0, 4))
        0: begin
          ch = 5'($urandom_range(0, 31));
          applyStimulus(1, ch, p, 0, '0, s);
          if (ch < NCH) expectFrame(ch, p);
          else expectDrop(s + 1, 1);
        end
        1: begin
          ch = 5'($urandom_range(0, NCH - 1));
          applyStimulus(1, ch, p, 1, c1, s);
          expectFrame(ch, p);
          expectLaunch(c1, 1, 0);
        end
        2: begin
          applyStimulus(0, 5'd0, p, 1, c1, s);
          expectLaunch(c1, 0, s + 1);
        end
        3: begin
          ch = 5'($urandom_range(0, NCH - 1));
          applyStimulus(1, ch, p, 0, '0, s);
          expectFrame(ch, p);
          repeat ($urandom_range(1, 10)) tick();
          applyStimulus(1, 5'($urandom_range(0, 31)), makePayload(0, 0), 0, '0, s);
          expectDrop(s + 1, 1);
          repeat (3) tick();
          applyStimulus(0, 5'd0, p, 1, c1, s);
          repeat (3) tick();
          applyStimulus(1, 5'd1, makePayload(0, 0), 1, c2, s);
          expectDrop(s + 1, 2);
          expectLaunch(c2, 1, 0);
        end
        default: begin
          applyStimulus(0, 5'd0, p, 1, c1, s);
          expectLaunch(c1, 0, s + 1);
          applyStimulus(0, 5'd0, p, 1, c2, s);
          expectLaunch(c2, 0, s + 2);
        end
      endcase
      waitQuiet("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dc_update_sequencer.md
# dc_update_sequencer

Sequences DC-bias updates and launch commands from the DC command dispatcher toward the DAC write engine. It captures each decoded channel frame, streams it word by word over a valid/ready link with channel and address tags, then enforces a settle interval before a queued launch command is released. It sits between the dispatcher (frame/launch strobes) and the DAC SPI write engine. It also arbitrates ordering, drops frames that arrive while busy, and reports status.

## Interface
- DAC_CHANNEL, 24, number of DAC channels; legal channel index 0..DAC_CHANNEL-1
- N_WORDS, 61, payload words per channel frame
- SETTLE_CYCLES, 16, idle cycles between the last accepted word and the launch strobe (≥1)

- i_clk  in  1  clock
- i_rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- i_frame_valid  in  1  one-cycle strobe: new frame on i_dc_regs/i_channel_sel
- i_channel_sel  in  5  target channel of the frame
- i_dc_regs  in  N_WORDS×32  frame payload, word 0 = first word written
- i_launch_valid  in  1  one-cycle strobe: launch command on i_launch_cmd
- i_launch_cmd  in  4×32  launch command words
- o_wr_valid  out  1  write word available
- i_wr_ready  in  1  write engine accepts word when high with o_wr_valid
- o_wr_channel  out  5  channel of current word
- o_wr_addr  out  6  word index 0..N_WORDS-1
- o_wr_data  out  32  word data
- o_frame_done  out  1  one-cycle pulse after last word of a frame is accepted
- o_launch_start  out  1  one-cycle launch strobe
- o_launch_cmd  out  4×32  latched launch command, stable from o_launch_start until next launch
- o_busy  out  1  high in any state other than IDLE
- o_drop  out  1  one-cycle pulse when a frame or launch is discarded
- o_drop_cnt  out  16  saturating count of discards

## Operation
- States: IDLE, STREAM, SETTLE, LAUNCH.
- IDLE + i_frame_valid with i_channel_sel < DAC_CHANNEL: latch payload and channel into shadow buffer, word index = 0, go STREAM.
- IDLE + i_frame_valid with i_channel_sel ≥ DAC_CHANNEL: discard, o_drop, stay IDLE.
- IDLE + i_launch_valid alone: latch command, go LAUNCH.
- IDLE + both strobes in the same cycle: frame goes to STREAM, launch goes to pending slot. Frame is always ordered before launch.
- STREAM: o_wr_valid = 1. o_wr_data = buffer[index], o_wr_addr = index. Index advances on valid&ready.
  - On acceptance of index N_WORDS-1: pulse o_frame_done next cycle.
  - If launch pending, go SETTLE with counter = SETTLE_CYCLES; otherwise go IDLE.
- SETTLE: counter decrements each cycle. At 1, go LAUNCH.
- LAUNCH: copy pending command to o_launch_cmd, assert o_launch_start for one cycle, clear pending, go IDLE.
- i_frame_valid in STREAM/SETTLE/LAUNCH: frame discarded, o_drop. The shadow buffer is never modified mid-stream.
- i_launch_valid in STREAM/SETTLE while pending slot empty: latch into pending slot, no drop.
- i_launch_valid while pending slot full: new command replaces pending, o_drop.
- i_launch_valid in LAUNCH state: latched as new pending. Serviced from IDLE next cycle (goes LAUNCH directly, no settle).
- o_drop_cnt increments by 1 per discard and saturates at 0xFFFF. A frame drop and a launch drop in the same cycle count 2, capped at 0xFFFF.

## Timing
- Reset values:
  - All outputs 0.
  - State IDLE, pending slot empty, counters 0.
  - Reset asserted mid-stream aborts immediately: o_wr_valid drops asynchronously and the pending launch is lost.
- Frame strobe at edge T (IDLE) → o_wr_valid high from T+1. With i_wr_ready tied high, one word per cycle: words on T+1..T+N_WORDS.
- o_frame_done pulses at T+N_WORDS+1.
- o_wr_valid/channel/addr/data are held stable while o_wr_valid & !i_wr_ready. o_wr_valid never deasserts before acceptance.
- Last word accepted at edge L with launch pending:
  - State is SETTLE for SETTLE_CYCLES cycles.
  - o_launch_start is high in cycle L+SETTLE_CYCLES+1.
  - o_launch_cmd updates in the same cycle.
- Launch strobe in IDLE at edge T → o_launch_start at T+1.
- o_drop is registered: it pulses the cycle after the offending strobe.

## Test plan
- Frame ch=5, words 0x1000+i, ready tied high → 61 writes addr 0..60, data 0x1000..0x103C, channel 5, o_frame_done one cycle after addr 60.
- Same frame with i_wr_ready toggling 1-of-3 → identical word sequence, data held stable during stalls, no duplicates or skips.
- Frame and launch (cmd 0xA0..0xA3) in the same cycle → full stream, then exactly 16 idle cycles, then o_launch_start with o_launch_cmd = 0xA0..0xA3.
- Second frame mid-stream, then two launches during STREAM → frame dropped, second launch replaces first, o_drop_cnt = 2, only the second command launched.
- Frame with ch=24 → no writes, o_drop pulse, o_drop_cnt = 1; launch alone in IDLE → o_launch_start next cycle.
- Assert i_rst_n low at word 30 → o_wr_valid 0 immediately, all outputs 0. A new frame after release streams from addr 0.
